// File: rtl/dmem_sb_if.sv
// Data-bus width encoding and the Wishbone data-bus interface used by dmem_sb.
// The master drives the request fields and the slave returns data_read/ack.
package dmem_sb_pkg;
    typedef enum logic [1:0] {
        eDW_B = 2'd0,
        eDW_H = 2'd1,
        eDW_W = 2'd2
    } dw_e;
endpackage

interface wishbone_if #(
    parameter int XLEN = 32
);
    import dmem_sb_pkg::*;

    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data_write;
    logic [XLEN-1:0] data_read;
    logic            we;
    logic            stb;
    logic            cyc;
    logic            ack;
    dw_e             width;

    modport master (
        output addr, data_write, we, stb, cyc, width,
        input  data_read, ack
    );

    modport slave (
        input  addr, data_write, we, stb, cyc, width,
        output data_read, ack
    );
endinterface

// File: rtl/dmem_sb.sv
// Data memory port with posted-store buffer; stores retire on enqueue, loads bypass unless same word.
// Load latency: issue the cycle after request, result in the ack cycle. Stalls on full buffer, load wait, fence.
// Optional DMEM_TIMEOUT_EN: abort a bus cycle after TIMEOUT unacked cycles and pulse oBusErr.
module dmem_sb
    import dmem_sb_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int SB_DEPTH = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic            clk,
    input  logic            nRst,
    input  logic [2:0]      iFunc3,
    input  logic            iEn,
    input  logic            iWrite,
    input  logic            iFence,
    input  logic [XLEN-1:0] iAddr,
    input  logic [XLEN-1:0] iData,
    output logic [XLEN-1:0] oData,
    output logic            oStall,
    output logic            oSbEmpty,
    output logic            oBusErr,
    wishbone_if.master      mem_wb
);
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE} state_e;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [XLEN-1:0]   sb_addr_q [SB_DEPTH];
    logic [XLEN-1:0]   sb_addr_d [SB_DEPTH];
    logic [XLEN-1:0]   sb_data_q [SB_DEPTH];
    logic [XLEN-1:0]   sb_data_d [SB_DEPTH];
    logic [1:0]        sb_f3_q   [SB_DEPTH];
    logic [1:0]        sb_f3_d   [SB_DEPTH];

    logic              cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [XLEN-1:0]   bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
    dw_e               bus_width_q, bus_width_d;
    logic [2:0]        ld_f3_q, ld_f3_d;
    logic [XLEN-1:0]   odata_q, odata_d;

    logic              load_req, store_req, hazard, full;
    logic              tmo_hit, done, ld_done, st_done, push;
    logic [XLEN-1:0]   ld_data;
    logic [PTR_W-1:0]  nxt_head;

    function automatic dw_e f3_to_dw(input logic [1:0] f);
        case (f)
            2'b00:   return eDW_B;
            2'b01:   return eDW_H;
            default: return eDW_W;
        endcase
    endfunction

    // The bus already returns the addressed lane in the low bits, zero-extended.
    function automatic logic [XLEN-1:0] extend(input logic [2:0] f3, input logic [XLEN-1:0] d);
        case (f3)
            3'b000:  return {{(XLEN-8){d[7]}}, d[7:0]};
            3'b001:  return {{(XLEN-16){d[15]}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    assign load_req  = iEn & ~iWrite;
    assign store_req = iEn & iWrite;
    assign full      = (count_q == CNT_W'(SB_DEPTH));

`ifdef DMEM_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;

    assign tmo_hit = cyc_q & ~mem_wb.ack & (tmo_q == TMO_W'(TIMEOUT - 1));

    always_comb begin
        tmo_d = '0;
        if (cyc_q && !mem_wb.ack && !tmo_hit) tmo_d = tmo_q + TMO_W'(1);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) tmo_q <= '0;
        else       tmo_q <= tmo_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign done     = cyc_q & (mem_wb.ack | tmo_hit);
    assign ld_done  = (state_q == S_LOAD) & done;
    assign st_done  = (state_q == S_STORE) & done;
    assign push     = store_req & (~full | st_done);
    assign ld_data  = tmo_hit ? '0 : extend(ld_f3_q, mem_wb.data_read);
    assign nxt_head = head_q + PTR_W'(1);

    // Word-granular match against every live entry, walking from head.
    always_comb begin
        logic [PTR_W-1:0] idx;
        hazard = 1'b0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            idx = head_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (sb_addr_q[idx][XLEN-1:2] == iAddr[XLEN-1:2]))
                hazard = 1'b1;
        end
    end

    always_comb begin
        sb_addr_d = sb_addr_q;
        sb_data_d = sb_data_q;
        sb_f3_d   = sb_f3_q;
        if (push) begin
            sb_addr_d[tail_q] = iAddr;
            sb_data_d[tail_q] = iData;
            sb_f3_d[tail_q]   = iFunc3[1:0];
        end
        head_d  = head_q + PTR_W'(st_done);
        tail_d  = tail_q + PTR_W'(push);
        count_d = count_q + CNT_W'(push) - CNT_W'(st_done);
    end

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_width_d = bus_width_q;
        ld_f3_d     = ld_f3_q;
        odata_d     = ld_done ? ld_data : odata_q;
        case (state_q)
            S_IDLE: begin
                if (load_req && !hazard) begin
                    state_d     = S_LOAD;
                    cyc_d       = 1'b1;
                    stb_d       = 1'b1;
                    we_d        = 1'b0;
                    bus_addr_d  = iAddr;
                    bus_width_d = f3_to_dw(iFunc3[1:0]);
                    ld_f3_d     = iFunc3;
                end else if (count_q != '0) begin
                    state_d     = S_STORE;
                    cyc_d       = 1'b1;
                    stb_d       = 1'b1;
                    we_d        = 1'b1;
                    bus_addr_d  = sb_addr_q[head_q];
                    bus_wdata_d = sb_data_q[head_q];
                    bus_width_d = f3_to_dw(sb_f3_q[head_q]);
                end
            end
            S_LOAD: begin
                if (done) begin
                    state_d = S_IDLE;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                end
            end
            S_STORE: begin
                // Back-to-back drain only from entries already resident; a pending load breaks the burst.
                if (done) begin
                    if (count_q > CNT_W'(1) && !load_req) begin
                        bus_addr_d  = sb_addr_q[nxt_head];
                        bus_wdata_d = sb_data_q[nxt_head];
                        bus_width_d = f3_to_dw(sb_f3_q[nxt_head]);
                    end else begin
                        state_d = S_IDLE;
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                        we_d    = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= S_IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_width_q <= eDW_W;
            ld_f3_q     <= 3'b010;
            odata_q     <= '0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                sb_addr_q[i] <= '0;
                sb_data_q[i] <= '0;
                sb_f3_q[i]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_width_q <= bus_width_d;
            ld_f3_q     <= ld_f3_d;
            odata_q     <= odata_d;
            sb_addr_q   <= sb_addr_d;
            sb_data_q   <= sb_data_d;
            sb_f3_q     <= sb_f3_d;
        end
    end

    assign oStall   = (load_req & ~ld_done)
                    | (store_req & full & ~st_done)
                    | (iFence & ~((count_q == '0) & (state_q == S_IDLE)));
    assign oData    = odata_d;
    assign oSbEmpty = (count_q == '0) & (state_q != S_STORE);
    assign oBusErr  = tmo_hit;

    assign mem_wb.cyc        = cyc_q;
    assign mem_wb.stb        = stb_q;
    assign mem_wb.we         = we_q;
    assign mem_wb.addr       = bus_addr_q;
    assign mem_wb.data_write = bus_wdata_q;
    assign mem_wb.width      = bus_width_q;
endmodule

// File: tb/tb_dmem_sb.sv
// Directed bench for dmem_sb: bench plays the bus slave by driving ack/data_read per cycle.
module tb_dmem_sb;
    import dmem_sb_pkg::*;

`ifdef DMEM_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic        clk;
    logic        nRst;
    logic [2:0]  iFunc3;
    logic        iEn, iWrite, iFence;
    logic [31:0] iAddr, iData;
    logic [31:0] oData;
    logic        oStall, oSbEmpty, oBusErr;

    int checks = 0;
    int errors = 0;

    wishbone_if #(.XLEN(32)) wb();

    dmem_sb #(.XLEN(32), .SB_DEPTH(4), .TIMEOUT(TMO)) dut (
        .clk      (clk),
        .nRst     (nRst),
        .iFunc3   (iFunc3),
        .iEn      (iEn),
        .iWrite   (iWrite),
        .iFence   (iFence),
        .iAddr    (iAddr),
        .iData    (iData),
        .oData    (oData),
        .oStall   (oStall),
        .oSbEmpty (oSbEmpty),
        .oBusErr  (oBusErr),
        .mem_wb   (wb.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 2 time units later.
    task automatic step(input logic en, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input logic ack);
        @(negedge clk);
        iEn = en; iWrite = wr; iFunc3 = f3; iAddr = a; iData = d; wb.ack = ack;
        #2;
    endtask

    task automatic idle(input logic ack);
        step(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, ack);
    endtask

    initial begin
        nRst = 1'b1; iEn = 0; iWrite = 0; iFence = 0; iFunc3 = 3'b010;
        iAddr = '0; iData = '0; wb.ack = 1'b0; wb.data_read = '0;
        #1 nRst = 1'b0;
        @(negedge clk); #2;
        check("rst_odata",  oData, 32'h0);
        check("rst_stall",  32'(oStall), 32'h0);
        check("rst_empty",  32'(oSbEmpty), 32'h1);
        check("rst_buserr", 32'(oBusErr), 32'h0);
        check("rst_cyc",    32'(wb.cyc), 32'h0);
        check("rst_stb",    32'(wb.stb), 32'h0);
        check("rst_we",     32'(wb.we), 32'h0);
        check("rst_addr",   wb.addr, 32'h0);
        check("rst_wdata",  wb.data_write, 32'h0);
        check("rst_width",  32'(wb.width), 32'(eDW_W));
        @(negedge clk); nRst = 1'b1;

        // Posted SW with slow ack
        step(1, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0);
        check("sw_issue_stall", 32'(oStall), 32'h0);
        idle(0);
        check("sw_empty_busy", 32'(oSbEmpty), 32'h0);
        idle(0);
        check("sw_cyc", 32'(wb.cyc), 32'h1);
        check("sw_we", 32'(wb.we), 32'h1);
        check("sw_addr", wb.addr, 32'h100);
        check("sw_wdata", wb.data_write, 32'hDEADBEEF);
        check("sw_width", 32'(wb.width), 32'(eDW_W));
        idle(0);
        check("sw_addr_hold", wb.addr, 32'h100);
        idle(1);
        check("sw_empty_ack", 32'(oSbEmpty), 32'h0);
        idle(0);
        check("sw_empty_after", 32'(oSbEmpty), 32'h1);
        check("sw_cyc_after", 32'(wb.cyc), 32'h0);

        // Five stores into a 4-deep buffer with ack withheld
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 3'b010, 32'h10 + 32'(4 * i), 32'(i + 1), 0);
            check("fill_nostall", 32'(oStall), 32'h0);
        end
        step(1, 1, 3'b010, 32'h20, 32'h5, 0);
        check("full_stall_a", 32'(oStall), 32'h1);
        step(1, 1, 3'b010, 32'h20, 32'h5, 0);
        check("full_stall_b", 32'(oStall), 32'h1);
        check("full_bus_head", wb.addr, 32'h10);
        step(1, 1, 3'b010, 32'h20, 32'h5, 1);
        check("full_accept", 32'(oStall), 32'h0);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            check("drain_addr", wb.addr, 32'h14 + 32'(4 * i));
            check("drain_wdata", wb.data_write, 32'(i + 2));
        end
        idle(0);
        check("drain_cyc", 32'(wb.cyc), 32'h0);
        check("drain_empty", 32'(oSbEmpty), 32'h1);

        // Same-word load waits for the store to drain
        step(1, 1, 3'b010, 32'h200, 32'h11223344, 0);
        step(1, 0, 3'b000, 32'h203, 32'h0, 0);
        check("haz_stall_a", 32'(oStall), 32'h1);
        step(1, 0, 3'b000, 32'h203, 32'h0, 0);
        check("haz_store_first", wb.addr, 32'h200);
        check("haz_stall_b", 32'(oStall), 32'h1);
        step(1, 0, 3'b000, 32'h203, 32'h0, 1);
        check("haz_stall_ack", 32'(oStall), 32'h1);
        step(1, 0, 3'b000, 32'h203, 32'h0, 0);
        check("haz_stall_idle", 32'(oStall), 32'h1);
        wb.data_read = 32'h80;
        step(1, 0, 3'b000, 32'h203, 32'h0, 1);
        check("lb_addr", wb.addr, 32'h203);
        check("lb_we", 32'(wb.we), 32'h0);
        check("lb_width", 32'(wb.width), 32'(eDW_B));
        check("lb_stall", 32'(oStall), 32'h0);
        check("lb_data", oData, 32'hFFFFFF80);
        idle(0);
        wb.data_read = 32'h0;
        check("lb_data_hold", oData, 32'hFFFFFF80);
        check("lb_cyc_drop", 32'(wb.cyc), 32'h0);

        // Different-word load bypasses a buffered store
        step(1, 1, 3'b010, 32'h300, 32'hCAFE0000, 0);
        step(1, 0, 3'b101, 32'h404, 32'h0, 0);
        check("lhu_stall", 32'(oStall), 32'h1);
        wb.data_read = 32'h8001;
        step(1, 0, 3'b101, 32'h404, 32'h0, 1);
        check("lhu_first", wb.addr, 32'h404);
        check("lhu_width", 32'(wb.width), 32'(eDW_H));
        check("lhu_data", oData, 32'h00008001);
        idle(0);
        check("lhu_sb_busy", 32'(oSbEmpty), 32'h0);
        idle(1);
        check("lhu_store_addr", wb.addr, 32'h300);
        idle(0);
        check("lhu_sb_empty", 32'(oSbEmpty), 32'h1);

        // Fence holds until three buffered stores are acked
        for (int i = 0; i < 3; i++) step(1, 1, 3'b010, 32'h500 + 32'(4 * i), 32'(i), 0);
        iFence = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("fence_stall", 32'(oStall), 32'h1);
        end
        idle(0);
        check("fence_release", 32'(oStall), 32'h0);
        iFence = 1'b0;

        // Async reset in the middle of a store
        step(1, 1, 3'b010, 32'h600, 32'h6, 0);
        idle(0);
        idle(0);
        check("mid_cyc", 32'(wb.cyc), 32'h1);
        nRst = 1'b0;
        #1;
        check("arst_cyc", 32'(wb.cyc), 32'h0);
        check("arst_empty", 32'(oSbEmpty), 32'h1);
        @(negedge clk); nRst = 1'b1;
        idle(0);
        idle(0);
        check("arst_discard", 32'(wb.cyc), 32'h0);

`ifdef DMEM_TIMEOUT_EN
        // Unacked LW aborts after TIMEOUT bus cycles
        step(1, 0, 3'b010, 32'h700, 32'h0, 0);
        for (int i = 0; i < TMO - 1; i++) begin
            step(1, 0, 3'b010, 32'h700, 32'h0, 0);
            check("tmo_wait_err", 32'(oBusErr), 32'h0);
            check("tmo_wait_stall", 32'(oStall), 32'h1);
        end
        step(1, 0, 3'b010, 32'h700, 32'h0, 0);
        check("tmo_err", 32'(oBusErr), 32'h1);
        check("tmo_stall", 32'(oStall), 32'h0);
        check("tmo_data", oData, 32'h0);
        idle(0);
        check("tmo_err_pulse", 32'(oBusErr), 32'h0);
        check("tmo_cyc", 32'(wb.cyc), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
